// File: rtl/iobus_pkg.sv
// Shared types and constants for the IO bus initiator and its watchdog.
package iobus_pkg;

    localparam int IOBUS_AW  = 32;
    localparam int IOBUS_DW  = 32;
    localparam int IOBUS_BEW = 4;

    localparam int IOBUS_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IOM_IDLE   = 2'd0,
        IOM_STROBE = 2'd1,
        IOM_WAIT   = 2'd2,
        IOM_RESP   = 2'd3
    } iom_state_t;

endpackage

// File: rtl/iobus_wdt.sv
// WAIT-phase watchdog: counts cycles without IO_Ready and flags expiry at P_TIMEOUT-1.
module iobus_wdt
    import iobus_pkg::*;
#(
    parameter int P_TIMEOUT = IOBUS_TIMEOUT_DEFAULT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(P_TIMEOUT - 1);

    logic [15:0] count_reg;

    // Saturates at LAST so a stalled master never wraps back to a live count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/iobus_master.sv
// MicroBlaze MCS IO bus initiator: one accepted command -> one bus transaction -> one response.
// Build option IOBUS_TIMEOUT_EN: unanswered transactions end with rsp_err after P_TIMEOUT WAIT cycles.
module iobus_master
    import iobus_pkg::*;
#(
    parameter int                  P_TIMEOUT   = IOBUS_TIMEOUT_DEFAULT,
    parameter logic [IOBUS_DW-1:0] P_ERR_RDATA = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [IOBUS_AW-1:0]  cmd_addr,
    input  logic [IOBUS_BEW-1:0] cmd_be,
    input  logic [IOBUS_DW-1:0]  cmd_wdata,
    output logic                 rsp_valid,
    output logic [IOBUS_DW-1:0]  rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 IO_Addr_Strobe,
    output logic                 IO_Read_Strobe,
    output logic                 IO_Write_Strobe,
    output logic [IOBUS_AW-1:0]  IO_Address,
    output logic [IOBUS_BEW-1:0] IO_Byte_Enable,
    output logic [IOBUS_DW-1:0]  IO_Write_Data,
    input  logic                 IO_Ready,
    input  logic [IOBUS_DW-1:0]  IO_Read_Data
);

    iom_state_t state_reg;
    logic       write_reg;
    logic       wdt_expired;

`ifdef IOBUS_TIMEOUT_EN
    iobus_wdt #(
        .P_TIMEOUT(P_TIMEOUT)
    ) u_wdt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (state_reg == IOM_STROBE),
        .enable ((state_reg == IOM_WAIT) && !IO_Ready),
        .expired(wdt_expired)
    );
`else
    // Watchdog compiled out: never expires, so WAIT only ends on IO_Ready.
    assign wdt_expired = (P_TIMEOUT < 0);
`endif

    // cmd_ready comes up one cycle after reset release, so accept is gated on it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IOM_IDLE;
            write_reg       <= 1'b0;
            cmd_ready       <= 1'b0;
            busy            <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            IO_Addr_Strobe  <= 1'b0;
            IO_Read_Strobe  <= 1'b0;
            IO_Write_Strobe <= 1'b0;
            IO_Address      <= '0;
            IO_Byte_Enable  <= '0;
            IO_Write_Data   <= '0;
        end else begin
            rsp_valid       <= 1'b0;
            IO_Addr_Strobe  <= 1'b0;
            IO_Read_Strobe  <= 1'b0;
            IO_Write_Strobe <= 1'b0;
            case (state_reg)
                IOM_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        write_reg       <= cmd_write;
                        IO_Address      <= cmd_addr;
                        IO_Byte_Enable  <= cmd_be;
                        IO_Write_Data   <= cmd_wdata;
                        IO_Addr_Strobe  <= 1'b1;
                        IO_Write_Strobe <= cmd_write;
                        IO_Read_Strobe  <= !cmd_write;
                        cmd_ready       <= 1'b0;
                        busy            <= 1'b1;
                        state_reg       <= IOM_STROBE;
                    end
                end
                IOM_STROBE: begin
                    state_reg <= IOM_WAIT;
                end
                IOM_WAIT: begin
                    // Ready takes priority over a watchdog expiry in the same cycle.
                    if (IO_Ready) begin
                        rsp_rdata <= write_reg ? '0 : IO_Read_Data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_reg <= IOM_RESP;
                    end else if (wdt_expired) begin
                        rsp_rdata <= P_ERR_RDATA;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state_reg <= IOM_RESP;
                    end
                end
                IOM_RESP: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state_reg <= IOM_IDLE;
                end
                default: begin
                    state_reg <= IOM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iobus_master.sv
// Scoreboard bench for iobus_master with a small register slave model; honours IOBUS_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_iobus_master;
    import iobus_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe;
    logic [31:0] IO_Address, IO_Write_Data;
    logic [3:0]  IO_Byte_Enable;
    logic        IO_Ready;
    logic [31:0] IO_Read_Data;

    always #5 Clk = ~Clk;

    iobus_master #(
        .P_TIMEOUT  (16),
        .P_ERR_RDATA(32'h0000_0000)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_be         (cmd_be),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .IO_Addr_Strobe (IO_Addr_Strobe),
        .IO_Read_Strobe (IO_Read_Strobe),
        .IO_Write_Strobe(IO_Write_Strobe),
        .IO_Address     (IO_Address),
        .IO_Byte_Enable (IO_Byte_Enable),
        .IO_Write_Data  (IO_Write_Data),
        .IO_Ready       (IO_Ready),
        .IO_Read_Data   (IO_Read_Data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_cmds = 0;
    int   n_strobes = 0;
    int   cyc = 0;
    logic prev_strobe = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- slave model ----------------
    int          slave_mode = 0;   // 0: in-range only, 1: Ready always high, 2: answer any address
    int          slave_delay = 1;
    logic [31:0] regs [2];
    logic [31:0] cur_addr = '0;
    bit          pending = 0;
    int          cnt = 0;

    function automatic bit in_range(input logic [31:0] a);
        return a[31:3] == 29'h1800_0000;
    endfunction

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return in_range(a) ? regs[a[2]] : ~a;
    endfunction

    initial begin
        IO_Ready = 1'b0;
        IO_Read_Data = '0;
        regs[0] = '0;
        regs[1] = '0;
        forever begin
            @(posedge Clk);
            #1;
            if (Reset) begin
                pending = 0;
                IO_Ready = (slave_mode == 1);
                continue;
            end
            if (slave_mode == 1) begin
                IO_Ready = 1'b1;
                IO_Read_Data = slave_data(cur_addr);
                pending = 0;
            end else if (pending && cnt == 1) begin
                IO_Ready = 1'b1;
                IO_Read_Data = slave_data(cur_addr);
                pending = 0;
            end else begin
                IO_Ready = 1'b0;
                IO_Read_Data = 32'hBAD0_BAD0;
                if (pending) cnt--;
            end
            if (IO_Addr_Strobe) begin
                cur_addr = IO_Address;
                if (IO_Write_Strobe && in_range(IO_Address))
                    for (int b = 0; b < 4; b++)
                        if (IO_Byte_Enable[b]) regs[IO_Address[2]][8*b +: 8] = IO_Write_Data[8*b +: 8];
                if (slave_mode != 1 && (in_range(IO_Address) || slave_mode == 2)) begin
                    pending = 1;
                    cnt = slave_delay;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_strobe = 1'b0;
                continue;
            end
            if (IO_Read_Strobe || IO_Write_Strobe) check("strobe_pair", 32'(IO_Addr_Strobe), 32'd1);
            if (IO_Addr_Strobe) begin
                n_strobes++;
                check("strobe_width", 32'(prev_strobe), 32'd0);
                check("strobe_rw", 32'(IO_Read_Strobe ^ IO_Write_Strobe), 32'd1);
            end
            prev_strobe = IO_Addr_Strobe;
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                    check("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    check("busy_at_rsp", 32'(busy), 32'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input bit expect_rsp);
        exp_t e;
        wait_ready();
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_be    = be;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        if (expect_rsp) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.acc   = cyc;
            e.lat   = lat;
            sb_q.push_back(e);
        end
        n_cmds++;
        @(posedge Clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = ~wd;
        cmd_be    = ~be;
        check("strobe_n1", 32'(IO_Addr_Strobe), 32'd1);
        check("write_strobe_n1", 32'(IO_Write_Strobe), 32'(wr));
        check("io_address", IO_Address, addr);
        check("io_be", 32'(IO_Byte_Enable), 32'(be));
        check("io_wdata", IO_Write_Data, wd);
        check("busy_n1", 32'(busy), 32'd1);
        check("cmd_ready_n1", 32'(cmd_ready), 32'd0);
        @(negedge Clk);
    endtask

    task automatic drain(input int bound);
        int waited = 0;
        while (sb_q.size() != 0 && waited < bound) begin
            @(negedge Clk);
            waited++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] acc_addr;
        exp_t        e;
        Reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_be = '0;
        cmd_wdata = '0;
        acc_addr = '0;
        repeat (3) @(negedge Clk);
        check("rst_flags", 32'({IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe, rsp_valid, rsp_err, busy}), 32'd0);
        check("rst_bus", IO_Address | IO_Write_Data | 32'(IO_Byte_Enable), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write then read back through the register slave
        send(1'b1, 32'hC000_0000, 4'b0011, 32'h1234_5678, 32'h0, 1'b0, 3, 1);
        send(1'b0, 32'hC000_0000, 4'hF,    32'h0,         32'h0000_5678, 1'b0, 3, 1);
        drain(20);

        // Stale Ready held high through idle must not complete early
        slave_mode = 1;
        repeat (5) @(negedge Clk);
        send(1'b0, 32'hC000_0000, 4'hF, 32'h0, 32'h0000_5678, 1'b0, 3, 1);
        drain(20);
        slave_mode = 0;
        repeat (2) @(negedge Clk);

        // Ready on the 16th WAIT cycle
        slave_delay = 16;
        send(1'b0, 32'hC000_0000, 4'hF, 32'h0, 32'h0000_5678, 1'b0, 18, 1);
        drain(40);
        slave_delay = 1;

        // Unanswered read
`ifdef IOBUS_TIMEOUT_EN
        send(1'b0, 32'hC000_0010, 4'hF, 32'h0, 32'h0000_0000, 1'b1, 18, 1);
        drain(40);
        send(1'b0, 32'hC000_0010, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0);
        repeat (3) @(negedge Clk);
`else
        send(1'b0, 32'hC000_0010, 4'hF, 32'h0, 32'h0, 1'b0, 0, 0);
        repeat (100) @(negedge Clk);
`endif
        check("busy_in_wait", 32'(busy), 32'd1);

        // Asynchronous reset while in WAIT
        #2 Reset = 1'b1;
        #1;
        check("arst_flags", 32'({IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe, rsp_valid, rsp_err, busy, cmd_ready}), 32'd0);
        check("arst_bus", IO_Address | IO_Write_Data | 32'(IO_Byte_Enable), 32'd0);
        check("arst_rdata", rsp_rdata, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("cmd_ready_after_arst", 32'(cmd_ready), 32'd1);
        send(1'b1, 32'hC000_0004, 4'hF, 32'hA5A5_1234, 32'h0, 1'b0, 3, 1);
        send(1'b0, 32'hC000_0004, 4'hF, 32'h0, 32'hA5A5_1234, 1'b0, 3, 1);
        drain(20);

        // cmd_valid held high with the address changing every cycle
        slave_mode = 2;
        wait_ready();
        cmd_write = 1'b0;
        cmd_be = 4'hF;
        cmd_wdata = '0;
        for (int k = 0; k < 16; k++) begin
            a = 32'hA000_0000 + 32'(k) * 32'd16;
            cmd_addr = a;
            cmd_valid = 1'b1;
            if (k % 4 == 0) begin
                check("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
                e.rdata = ~a;
                e.err = 1'b0;
                e.acc = cyc;
                e.lat = 3;
                sb_q.push_back(e);
                n_cmds++;
                acc_addr = a;
            end else begin
                check("b2b_cmd_ready_busy", 32'(cmd_ready), 32'd0);
            end
            if (k % 4 == 1) check("b2b_address", IO_Address, acc_addr);
            @(negedge Clk);
        end
        cmd_valid = 1'b0;
        drain(20);
        slave_mode = 0;

        check("strobe_count", 32'(n_strobes), 32'(n_cmds));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
